fetch_pc_gen: RTL and testbench

Parametrised next-generation fetch PC generator for the LoongArch frontend. It produces fetch-group addresses for the instruction cache over a valid/ready handshake and supports 1, 2 or 4 instructions per fetch. Per-slot valid masks cover branch targets that land mid-group, and a halt state stops fetching after an address-misaligned fetch until the backend redirects. It sits between the branch predictor / backend redirect logic and the icache request port.

---
 rtl/fetch_pc_gen_pkg.sv | 32 +++
 rtl/fetch_pc_gen.sv | 90 +++++++++
 tb/tb_fetch_pc_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fetch_pc_gen_pkg.sv
// Shared frontend definitions: exception causes, fetch FSM encoding and
// fetch-group geometry helpers used by the PC generator, predictor and fetch buffer.
package fetch_pc_gen_pkg;

    // Exception cause codes carried alongside fetch requests
    localparam logic [6:0] EXCEPTION_NOP  = 7'h00;
    localparam logic [6:0] EXCEPTION_ADEF = 7'h08;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // Default group geometry (FETCH_WIDTH = 2)
    localparam int unsigned FETCH_WIDTH_DEF = 2;

    // Bytes per fetch group
    function automatic int unsigned fetch_gb(input int unsigned fw);
        return 4 * fw;
    endfunction

    // Width of the slot index inside a group (at least 1 bit so it can be declared)
    function automatic int unsigned fetch_slot_w(input int unsigned fw);
        return (fw > 1) ? $clog2(fw) : 1;
    endfunction

    localparam int unsigned GB_DEF     = fetch_gb(FETCH_WIDTH_DEF);
    localparam int unsigned SLOT_W_DEF = fetch_slot_w(FETCH_WIDTH_DEF);

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: presents one fetch group per handshake, follows predictor
// and backend redirects, steps single instructions for uncached fetch, and halts
// after a misaligned fetch until the backend redirects.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h1c000000,
    parameter int          FETCH_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [31:0]            flush_pc,
    input  logic                   pause,
    input  logic                   uncache,
    input  logic                   pred_taken,
    input  logic [31:0]            pred_pc,
    output logic                   ireq_valid,
    input  logic                   ireq_ready,
    output logic [31:0]            ireq_pc,
    output logic [FETCH_WIDTH-1:0] ireq_mask,
    output logic                   pc_excp,
    output logic [6:0]             pc_excp_cause
);

    localparam logic [31:0] GB_L = 32'(fetch_gb(FETCH_WIDTH));

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         misaligned, hs;

    // Slot valid mask: nothing for a misaligned pc, one slot when uncached,
    // otherwise the starting slot through the end of the group.
    function automatic logic [FETCH_WIDTH-1:0] gen_mask(input logic [31:0] pc, input logic unc);
        logic [FETCH_WIDTH-1:0] m;
        logic [31:0]            s;
        m = '0;
        s = (pc & (GB_L - 32'd1)) >> 2;
        if (pc[1:0] == 2'b00) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (unc ? (32'(i) == s) : (32'(i) >= s)) m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    assign misaligned    = pc_q[1:0] != 2'b00;
    assign ireq_valid    = (state_q == ST_RUN) && !pause && !flush;
    assign hs            = ireq_valid && ireq_ready;
    assign ireq_pc       = pc_q;
    assign ireq_mask     = gen_mask(pc_q, uncache);
    assign pc_excp       = misaligned && (state_q == ST_RUN);
    assign pc_excp_cause = pc_excp ? EXCEPTION_ADEF : EXCEPTION_NOP;

    // Next pc / state: redirect first, then halt on bad address, then sequencing
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (flush) begin
            pc_d    = flush_pc;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN: begin
                    if (hs) begin
                        if (misaligned)      state_d = ST_HALT;
                        else if (pred_taken) pc_d = pred_pc;
                        else if (uncache)    pc_d = pc_q + 32'd4;
                        else                 pc_d = (pc_q & ~(GB_L - 32'd1)) + GB_L;
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_BOOT;
            endcase
        end
    end

    // State and pc registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen (FETCH_WIDTH=2): stimulus pushes expected
// handshakes into a scoreboard queue, a negedge monitor pops and compares.
module tb_fetch_pc_gen;

    localparam logic [31:0] RST_PC = 32'h1c000000;
    localparam logic [6:0]  C_NOP  = 7'h00;
    localparam logic [6:0]  C_ADEF = 7'h08;

    logic        clk = 1'b0;
    logic        rst_n, flush, pause, uncache, pred_taken, ireq_ready;
    logic [31:0] flush_pc, pred_pc;
    logic        ireq_valid, pc_excp;
    logic [31:0] ireq_pc;
    logic [1:0]  ireq_mask;
    logic [6:0]  pc_excp_cause;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  mask;
        logic        excp;
        logic [6:0]  cause;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fetch_pc_gen #(.RESET_PC(RST_PC), .FETCH_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
        .pause(pause), .uncache(uncache), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .ireq_valid(ireq_valid), .ireq_ready(ireq_ready), .ireq_pc(ireq_pc),
        .ireq_mask(ireq_mask), .pc_excp(pc_excp), .pc_excp_cause(pc_excp_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [1:0] mask, input logic excp);
        exp_t e;
        e.pc = pc; e.mask = mask; e.excp = excp;
        e.cause = excp ? C_ADEF : C_NOP;
        sb.push_back(e);
    endtask

    // Advance to just after the next rising edge and restore default inputs
    task automatic cyc();
        @(posedge clk);
        #1;
        flush = 0; pause = 0; uncache = 0; pred_taken = 0; ireq_ready = 1;
    endtask

    // Monitor: every accepted request must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && ireq_valid && ireq_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL hs_unexpected: got pc %h, no request expected", ireq_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hs_pc",    ireq_pc, e.pc);
                chk("hs_mask",  32'(ireq_mask), 32'(e.mask));
                chk("hs_excp",  32'(pc_excp), 32'(e.excp));
                chk("hs_cause", 32'(pc_excp_cause), 32'(e.cause));
            end
        end
    end

    initial begin
        rst_n = 0; flush = 0; flush_pc = '0; pause = 0; uncache = 0;
        pred_taken = 0; pred_pc = '0; ireq_ready = 1;
        #12;
        chk("rst_valid", 32'(ireq_valid), 32'd0);
        chk("rst_pc",    ireq_pc, RST_PC);
        chk("rst_excp",  32'(pc_excp), 32'd0);
        chk("rst_cause", 32'(pc_excp_cause), 32'(C_NOP));
        @(posedge clk); #4; rst_n = 1; #1;
        chk("boot_valid", 32'(ireq_valid), 32'd0);

        // Sequential groups from reset
        push(32'h1c000000, 2'b11, 0);
        push(32'h1c000008, 2'b11, 0);
        cyc();                                   // C0 pc 000
        cyc();                                   // C1 pc 008
        // Stall with pause pulsed in the second stall cycle
        cyc(); ireq_ready = 0; #1;               // C2
        chk("hold1_valid", 32'(ireq_valid), 32'd1);
        chk("hold1_pc", ireq_pc, 32'h1c000010);
        cyc(); ireq_ready = 0; pause = 1; #1;    // C3
        chk("pause_valid", 32'(ireq_valid), 32'd0);
        chk("pause_pc", ireq_pc, 32'h1c000010);
        cyc(); ireq_ready = 0; #1;               // C4
        chk("hold3_valid", 32'(ireq_valid), 32'd1);
        chk("hold3_pc", ireq_pc, 32'h1c000010);
        // Single handshake on ready, with a predicted-taken branch
        push(32'h1c000010, 2'b11, 0);
        cyc(); pred_taken = 1; pred_pc = 32'h1c000104;   // C5
        push(32'h1c000104, 2'b10, 0);
        push(32'h1c000108, 2'b11, 0);
        cyc();                                   // C6 pc 104
        cyc();                                   // C7 pc 108
        // Redirect to 1c000000 then uncached stepping
        cyc(); flush = 1; flush_pc = 32'h1c000000; #1;   // C8
        chk("flush_valid", 32'(ireq_valid), 32'd0);
        push(32'h1c000000, 2'b01, 0);
        push(32'h1c000004, 2'b10, 0);
        push(32'h1c000008, 2'b01, 0);
        push(32'h1c00000c, 2'b10, 0);
        cyc(); uncache = 1;                      // C9
        cyc(); uncache = 1;                      // C10
        cyc(); uncache = 1;                      // C11
        cyc();                                   // C12 pc 00c cached, mid-group
        // Flush coincident with a would-be predicted handshake: flush wins
        cyc(); flush = 1; flush_pc = 32'h1c000102;
        pred_taken = 1; pred_pc = 32'h1c000500; #1;      // C13
        chk("flush_hs_valid", 32'(ireq_valid), 32'd0);
        // Misaligned request then halt
        push(32'h1c000102, 2'b00, 1);
        cyc();                                   // C14 pc 102
        cyc(); #1;                               // C15
        chk("halt_valid", 32'(ireq_valid), 32'd0);
        chk("halt_pc", ireq_pc, 32'h1c000102);
        chk("halt_excp", 32'(pc_excp), 32'd0);
        cyc(); #1;                               // C16
        chk("halt2_valid", 32'(ireq_valid), 32'd0);
        cyc(); flush = 1; flush_pc = 32'h1c000200;       // C17
        push(32'h1c000200, 2'b11, 0);
        cyc();                                   // C18 pc 200
        // Async reset in the middle of a stalled request
        cyc(); ireq_ready = 0; #1;               // C19 pc 208
        chk("pre_rst_pc", ireq_pc, 32'h1c000208);
        rst_n = 0; #1;
        chk("midrst_valid", 32'(ireq_valid), 32'd0);
        chk("midrst_pc", ireq_pc, RST_PC);
        rst_n = 1; #1;
        chk("reboot_valid", 32'(ireq_valid), 32'd0);
        push(32'h1c000000, 2'b11, 0);
        cyc();                                   // pc 000 again
        cyc(); ireq_ready = 0;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
